// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes, functs, ALU codes.
// ADDI states and opcode exist only when MC_ADDI_EN is defined.
package mips_mc_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FN_W     = 6;
  localparam int unsigned ALU_W    = 4;
  localparam int unsigned ST_ENC_W = 4;

  typedef enum logic [ST_ENC_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
`ifdef MC_ADDI_EN
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
`else
    S_JUMP     = 4'd9
`endif
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
`ifdef MC_ADDI_EN
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
`endif

  localparam logic [FN_W-1:0] FN_SLL = 6'h00;
  localparam logic [FN_W-1:0] FN_ADD = 6'h20;
  localparam logic [FN_W-1:0] FN_SUB = 6'h22;
  localparam logic [FN_W-1:0] FN_AND = 6'h24;
  localparam logic [FN_W-1:0] FN_OR  = 6'h25;
  localparam logic [FN_W-1:0] FN_NOR = 6'h27;
  localparam logic [FN_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_W-1:0] ALU_SLL = 4'd5;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'd7;
  localparam logic [ALU_W-1:0] ALU_NOR = 4'd12;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control word presented to the datapath each cycle.
  typedef struct packed {
    logic [ALU_W-1:0] alu_control;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsource;
    logic             pc_en;
    logic             iord;
    logic             memread;
    logic             memwrite;
    logic             irwrite;
    logic             memtoreg;
    logic             regwrite;
    logic             regdst;
    logic             illegal;
    logic             retire;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_ctrl_alu_func_dec.sv
// R-type funct decoder: maps funct to an ALU code and flags unsupported functs.
module alu_func_dec
  import mips_mc_ctrl_pkg::*;
(
  input  logic [FN_W-1:0]  i_funct,
  output logic [ALU_W-1:0] o_alu_control_c,
  output logic             o_illegal_c
);

  always_comb begin
    o_alu_control_c = ALU_AND;
    o_illegal_c     = 1'b0;
    case (i_funct)
      FN_ADD:  o_alu_control_c = ALU_ADD;
      FN_SUB:  o_alu_control_c = ALU_SUB;
      FN_AND:  o_alu_control_c = ALU_AND;
      FN_OR:   o_alu_control_c = ALU_OR;
      FN_NOR:  o_alu_control_c = ALU_NOR;
      FN_SLT:  o_alu_control_c = ALU_SLT;
      FN_SLL:  o_alu_control_c = ALU_SLL;
      default: o_illegal_c     = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM decoding the held IR into datapath controls.
// Define MC_ADDI_EN to add the ADDI_EX/ADDI_WB path for opcode 0x08.
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FN_W-1:0]    funct,
  input  logic               zero,
  input  logic               stall,
  output logic [ALU_W-1:0]   alu_control,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsource,
  output logic               pc_en,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               regdst,
  output logic               illegal,
  output logic               retire,
  output logic [STATE_W-1:0] state
);

  state_e           r_state;
  state_e           w_next_state;
  ctrl_t            w_ctrl;
  logic [ALU_W-1:0] w_fn_alu;
  logic             w_fn_illegal;

  alu_func_dec u_alu_func_dec (
    .i_funct         (funct),
    .o_alu_control_c (w_fn_alu),
    .o_illegal_c     (w_fn_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // Moore outputs per state; stall freezes the state and masks side-effecting strobes.
  always_comb begin
    w_ctrl       = '0;
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        w_ctrl.memread     = 1'b1;
        w_ctrl.irwrite     = 1'b1;
        w_ctrl.alusrcb     = SRCB_FOUR;
        w_ctrl.alu_control = ALU_ADD;
        w_ctrl.pcsource    = PCSRC_ALU;
        w_ctrl.pc_en       = 1'b1;
        w_next_state       = S_DECODE;
      end
      S_DECODE: begin
        w_ctrl.alusrcb     = SRCB_BOFF;
        w_ctrl.alu_control = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_RTYPE_EX;
          OP_BEQ:       w_next_state = S_BEQ;
          OP_J:         w_next_state = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      w_next_state = S_ADDI_EX;
`endif
          default: begin
            w_ctrl.illegal = 1'b1;
            w_next_state   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_ctrl.alusrca     = 1'b1;
        w_ctrl.alusrcb     = SRCB_IMM;
        w_ctrl.alu_control = ALU_ADD;
        w_next_state       = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_ctrl.memread = 1'b1;
        w_ctrl.iord    = 1'b1;
        w_next_state   = S_MEMWB;
      end
      S_MEMWB: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memtoreg = 1'b1;
        w_ctrl.retire   = 1'b1;
        w_next_state    = S_FETCH;
      end
      S_MEMWR: begin
        w_ctrl.memwrite = 1'b1;
        w_ctrl.iord     = 1'b1;
        w_ctrl.retire   = 1'b1;
        w_next_state    = S_FETCH;
      end
      S_RTYPE_EX: begin
        w_ctrl.alusrca     = 1'b1;
        w_ctrl.alusrcb     = SRCB_REG;
        w_ctrl.alu_control = w_fn_alu;
        w_ctrl.illegal     = w_fn_illegal;
        w_next_state       = w_fn_illegal ? S_FETCH : S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        w_ctrl.regdst   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.retire   = 1'b1;
        w_next_state    = S_FETCH;
      end
      S_BEQ: begin
        w_ctrl.alusrca     = 1'b1;
        w_ctrl.alusrcb     = SRCB_REG;
        w_ctrl.alu_control = ALU_SUB;
        w_ctrl.pcsource    = PCSRC_ALUOUT;
        w_ctrl.pc_en       = zero;
        w_ctrl.retire      = 1'b1;
        w_next_state       = S_FETCH;
      end
      S_JUMP: begin
        w_ctrl.pcsource = PCSRC_JUMP;
        w_ctrl.pc_en    = 1'b1;
        w_ctrl.retire   = 1'b1;
        w_next_state    = S_FETCH;
      end
`ifdef MC_ADDI_EN
      S_ADDI_EX: begin
        w_ctrl.alusrca     = 1'b1;
        w_ctrl.alusrcb     = SRCB_IMM;
        w_ctrl.alu_control = ALU_ADD;
        w_next_state       = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.retire   = 1'b1;
        w_next_state    = S_FETCH;
      end
`endif
      default: w_next_state = S_FETCH;
    endcase

    if (stall) begin
      w_next_state    = r_state;
      w_ctrl.pc_en    = 1'b0;
      w_ctrl.memwrite = 1'b0;
      w_ctrl.regwrite = 1'b0;
      w_ctrl.irwrite  = 1'b0;
      w_ctrl.retire   = 1'b0;
      w_ctrl.illegal  = 1'b0;
    end
  end

  assign alu_control = w_ctrl.alu_control;
  assign alusrca     = w_ctrl.alusrca;
  assign alusrcb     = w_ctrl.alusrcb;
  assign pcsource    = w_ctrl.pcsource;
  assign pc_en       = w_ctrl.pc_en;
  assign iord        = w_ctrl.iord;
  assign memread     = w_ctrl.memread;
  assign memwrite    = w_ctrl.memwrite;
  assign irwrite     = w_ctrl.irwrite;
  assign memtoreg    = w_ctrl.memtoreg;
  assign regwrite    = w_ctrl.regwrite;
  assign regdst      = w_ctrl.regdst;
  assign illegal     = w_ctrl.illegal;
  assign retire      = w_ctrl.retire;
  assign state       = STATE_W'(r_state);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-instruction state/strobe tables plus reset and stall sequences.
module tb_mips_mc_ctrl;

  localparam int FE = 0, DE = 1, MA = 2, MR = 3, MB = 4, MW = 5;
  localparam int RX = 6, RW = 7, BQ = 8, JP = 9, AX = 10, AW = 11;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct  = 6'h00;
  logic       zero   = 1'b0;
  logic       stall  = 1'b0;
  logic [3:0] alu_control;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic       pc_en, iord, memread, memwrite, irwrite;
  logic       memtoreg, regwrite, regdst, illegal, retire;
  logic [3:0] state;

  mips_mc_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .stall(stall),
    .alu_control(alu_control), .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
    .pc_en(pc_en), .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regwrite(regwrite), .regdst(regdst), .illegal(illegal),
    .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sample point is 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         len;
    int         st[5];
    int         ill;
    int         cc;
    int         alu;
    int         pcen;
    int         pcsrc;
    int         nrw;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input int len, input int s0, input int s1, input int s2,
                              input int s3, input int s4, input int ill, input int cc,
                              input int alu, input int pcen, input int pcsrc, input int nrw);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.len = len;
    v.st[0] = s0; v.st[1] = s1; v.st[2] = s2; v.st[3] = s3; v.st[4] = s4;
    v.ill = ill; v.cc = cc; v.alu = alu; v.pcen = pcen; v.pcsrc = pcsrc; v.nrw = nrw;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int nrw;
    nrw = 0;
    opcode = v.op;
    funct  = v.fn;
    zero   = v.z;
    #1;
    for (int c = 0; c < v.len; c++) begin
      if (c != 0) step();
      chk($sformatf("v%0d state c%0d", idx, c), int'(state), v.st[c]);
      chk($sformatf("v%0d retire c%0d", idx, c), int'(retire),
          (c == v.len - 1 && v.ill < 0) ? 1 : 0);
      chk($sformatf("v%0d illegal c%0d", idx, c), int'(illegal), (c == v.ill) ? 1 : 0);
      if (regwrite) nrw++;
      if (c == v.cc) begin
        chk($sformatf("v%0d alu_control", idx), int'(alu_control), v.alu);
        chk($sformatf("v%0d pc_en", idx), int'(pc_en), v.pcen);
        chk($sformatf("v%0d pcsource", idx), int'(pcsource), v.pcsrc);
      end
    end
    chk($sformatf("v%0d regwrite cycles", idx), nrw, v.nrw);
    step();
    chk($sformatf("v%0d back to fetch", idx), int'(state), FE);
  endtask

  initial begin
    vt.push_back(mk(6'h23, 6'h00, 1'b0, 5, FE, DE, MA, MR, MB, -1, 2, 2, 0, 0, 1));
    vt.push_back(mk(6'h2B, 6'h00, 1'b0, 4, FE, DE, MA, MW, 0,  -1, 3, 0, 0, 0, 0));
    vt.push_back(mk(6'h00, 6'h22, 1'b0, 4, FE, DE, RX, RW, 0,  -1, 2, 6, 0, 0, 1));
    vt.push_back(mk(6'h00, 6'h20, 1'b0, 4, FE, DE, RX, RW, 0,  -1, 2, 2, 0, 0, 1));
    vt.push_back(mk(6'h00, 6'h24, 1'b0, 4, FE, DE, RX, RW, 0,  -1, 2, 0, 0, 0, 1));
    vt.push_back(mk(6'h00, 6'h25, 1'b0, 4, FE, DE, RX, RW, 0,  -1, 2, 1, 0, 0, 1));
    vt.push_back(mk(6'h00, 6'h27, 1'b0, 4, FE, DE, RX, RW, 0,  -1, 2, 12, 0, 0, 1));
    vt.push_back(mk(6'h00, 6'h2A, 1'b0, 4, FE, DE, RX, RW, 0,  -1, 2, 7, 0, 0, 1));
    vt.push_back(mk(6'h00, 6'h00, 1'b0, 4, FE, DE, RX, RW, 0,  -1, 2, 5, 0, 0, 1));
    vt.push_back(mk(6'h00, 6'h3F, 1'b0, 3, FE, DE, RX, 0,  0,   2, 2, 0, 0, 0, 0));
    vt.push_back(mk(6'h04, 6'h00, 1'b1, 3, FE, DE, BQ, 0,  0,  -1, 2, 6, 1, 1, 0));
    vt.push_back(mk(6'h04, 6'h00, 1'b0, 3, FE, DE, BQ, 0,  0,  -1, 2, 6, 0, 1, 0));
    vt.push_back(mk(6'h02, 6'h00, 1'b0, 3, FE, DE, JP, 0,  0,  -1, 2, 0, 1, 2, 0));
    vt.push_back(mk(6'h3F, 6'h00, 1'b0, 2, FE, DE, 0,  0,  0,   1, 1, 2, 0, 0, 0));
    vt.push_back(mk(6'h0C, 6'h00, 1'b0, 2, FE, DE, 0,  0,  0,   1, 1, 2, 0, 0, 0));
`ifdef MC_ADDI_EN
    vt.push_back(mk(6'h08, 6'h00, 1'b0, 4, FE, DE, AX, AW, 0,  -1, 2, 2, 0, 0, 1));
`else
    vt.push_back(mk(6'h08, 6'h00, 1'b0, 2, FE, DE, 0,  0,  0,   1, 1, 2, 0, 0, 0));
`endif

    // Reset values equal FETCH outputs.
    step();
    step();
    chk("reset state", int'(state), FE);
    chk("reset memread", int'(memread), 1);
    chk("reset irwrite", int'(irwrite), 1);
    chk("reset pc_en", int'(pc_en), 1);
    chk("reset alusrcb", int'(alusrcb), 1);
    chk("reset alu_control", int'(alu_control), 2);
    chk("reset iord", int'(iord), 0);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

    // Asynchronous reset while in MEMRD.
    opcode = 6'h23;
    #1;
    step(); step(); step();
    chk("pre-reset state memrd", int'(state), MR);
    rst_n = 1'b0;
    #1;
    chk("midreset state", int'(state), FE);
    chk("midreset memread", int'(memread), 1);
    chk("midreset irwrite", int'(irwrite), 1);
    chk("midreset iord", int'(iord), 0);
    step();
    chk("held in reset", int'(state), FE);
    rst_n = 1'b1;

    // Stall in FETCH then a jump.
    stall = 1'b1;
    #1;
    chk("fetch stall pc_en", int'(pc_en), 0);
    chk("fetch stall irwrite", int'(irwrite), 0);
    chk("fetch stall memread", int'(memread), 1);
    step();
    chk("fetch stall held", int'(state), FE);
    stall  = 1'b0;
    opcode = 6'h02;
    step();
    chk("after stall decode", int'(state), DE);
    step();
    chk("jump state", int'(state), JP);
    chk("jump retire", int'(retire), 1);
    step();
    chk("jump to fetch", int'(state), FE);

    // Stall for 3 cycles in MEMWR.
    opcode = 6'h2B;
    #1;
    step(); step(); step();
    chk("memwr state", int'(state), MW);
    chk("memwr memwrite pre", int'(memwrite), 1);
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("memwr stall state %0d", i), int'(state), MW);
      chk($sformatf("memwr stall memwrite %0d", i), int'(memwrite), 0);
      chk($sformatf("memwr stall iord %0d", i), int'(iord), 1);
      chk($sformatf("memwr stall retire %0d", i), int'(retire), 0);
      step();
    end
    chk("memwr stall held end", int'(state), MW);
    stall = 1'b0;
    #1;
    chk("memwr release memwrite", int'(memwrite), 1);
    chk("memwr release retire", int'(retire), 1);
    step();
    chk("memwr then fetch", int'(state), FE);
    chk("fetch memwrite low", int'(memwrite), 0);

    // Stalled illegal decode must not flag illegal.
    opcode = 6'h3F;
    #1;
    step();
    stall = 1'b1;
    #1;
    chk("stalled decode illegal", int'(illegal), 0);
    step();
    chk("stalled decode held", int'(state), DE);
    stall = 1'b0;
    #1;
    chk("decode illegal released", int'(illegal), 1);
    step();
    chk("illegal back to fetch", int'(state), FE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
